// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
//   Round-robin scanner for an MCP3208-class 12-bit SPI ADC. Each frame drops
//   CS, clocks out start/SGL/channel command bits on DIN, shifts 12 result
//   bits in from DOUT and publishes one tagged sample.
//
// Parameters
//   CLK_DIV     SCK half-period in controlCLK cycles (>= 2)
//   GAP_CYCLES  minimum CS-high time between frames (>= 1)
//
// Ports
//   controlCLK      clock, rising edge
//   rst_n           asynchronous active-low reset
//   enable          continuous scanning while high
//   chMask[7:0]     channel enables, bit n = ADC channel n
//   CS, SCK, DIN    SPI outputs to the ADC (CS active low, SCK idles low)
//   DOUT            SPI data from the ADC
//   processCounter  current SCK period index 0..18, 0 outside SHIFT
//   sampleData      last conversion result
//   sampleCh        channel of sampleData
//   sampleValid     one-cycle strobe for a new sampleData/sampleCh
//   busy            high from CS fall until the inter-frame gap ends
//
// Build option
//   ADC_SCAN_OVERSAMPLE_EN  converts each channel in 4 frames and publishes
//                           the averaged 14-bit sum (accumulator[13:2]).
// ---------------------------------------------------------------------------
module adc_scan_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        controlCLK,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  chMask,
    output logic        CS,
    output logic        SCK,
    output logic        DIN,
    input  logic        DOUT,
    output logic [5:0]  processCounter,
    output logic [11:0] sampleData,
    output logic [2:0]  sampleCh,
    output logic        sampleValid,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [5:0] LAST_P       = 6'd18;
    localparam logic [5:0] FIRST_DATA_P = 6'd7;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;   // 0 = SCK low phase, 1 = high phase
    logic [5:0]        pc_q, pc_d;
    logic [2:0]        ch_q, ch_d;         // channel of current / last frame
    logic [11:0]       sh_q, sh_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              din_q, din_d;
    logic [11:0]       data_q, data_d;
    logic [2:0]        sch_q, sch_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
`ifdef ADC_SCAN_OVERSAMPLE_EN
    logic [13:0]       acc_q, acc_d;
    logic [1:0]        rep_q, rep_d;
    logic [13:0]       acc_sum;
`endif
    logic              start;

    // Next enabled channel strictly after 'last', wrapping 7->0. Reset leaves
    // 'last' at 7 so the first pick is the lowest set bit.
    function automatic logic [2:0] next_ch(input logic [2:0] last, input logic [7:0] mask);
        logic [2:0] c;
        logic [2:0] r;
        logic       found;
        r     = last;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            c = last + 3'(i);
            if (!found && mask[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Command bit for SCK period p: start, SGL, D2, D1, D0, then zeros.
    function automatic logic din_bit(input logic [5:0] p, input logic [2:0] ch);
        case (p)
            6'd0, 6'd1: din_bit = 1'b1;
            6'd2:       din_bit = ch[2];
            6'd3:       din_bit = ch[1];
            6'd4:       din_bit = ch[0];
            default:    din_bit = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        pc_d    = pc_q;
        ch_d    = ch_q;
        sh_d    = sh_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        din_d   = din_q;
        data_d  = data_q;
        sch_d   = sch_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        start   = 1'b0;
`ifdef ADC_SCAN_OVERSAMPLE_EN
        acc_d   = acc_q;
        rep_d   = rep_q;
        acc_sum = acc_q + {2'b00, sh_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (enable && (chMask != 8'h00)) start = 1'b1;
            end

            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    pc_d    = 6'd0;
                    din_d   = din_bit(6'd0, ch_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        // SCK rises on this edge; the ADC has held DOUT stable
                        // through the low phase, so it is captured directly.
                        sck_d   = 1'b1;
                        phase_d = 1'b1;
                        if (pc_q >= FIRST_DATA_P) sh_d = {sh_q[10:0], DOUT};
                    end else begin
                        sck_d   = 1'b0;
                        phase_d = 1'b0;
                        if (pc_q == LAST_P) begin
                            state_d = S_HOLD;
                            pc_d    = 6'd0;
                            din_d   = 1'b0;
                        end else begin
                            pc_d  = pc_q + 6'd1;
                            din_d = din_bit(pc_q + 6'd1, ch_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
`ifdef ADC_SCAN_OVERSAMPLE_EN
                    if (rep_q == 2'd3) begin
                        vld_d  = 1'b1;
                        data_d = acc_sum[13:2];
                        sch_d  = ch_q;
                        acc_d  = '0;
                        rep_d  = 2'd0;
                    end else begin
                        acc_d = acc_sum;
                        rep_d = rep_q + 2'd1;
                    end
`else
                    vld_d  = 1'b1;
                    data_d = sh_q;
                    sch_d  = ch_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
`ifdef ADC_SCAN_OVERSAMPLE_EN
                    // An unfinished group of 4 always runs to completion.
                    start = (enable && (chMask != 8'h00)) || (rep_q != 2'd0);
`else
                    start = enable && (chMask != 8'h00);
`endif
                    if (!start) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_SETUP;
            cnt_d   = '0;
            phase_d = 1'b0;
            pc_d    = 6'd0;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            din_d   = 1'b1;
            busy_d  = 1'b1;
`ifdef ADC_SCAN_OVERSAMPLE_EN
            if (rep_q == 2'd0) ch_d = next_ch(ch_q, chMask);
`else
            ch_d = next_ch(ch_q, chMask);
`endif
        end
    end

    always_ff @(posedge controlCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            pc_q    <= 6'd0;
            ch_q    <= 3'd7;
            sh_q    <= 12'h000;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            din_q   <= 1'b0;
            data_q  <= 12'h000;
            sch_q   <= 3'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ADC_SCAN_OVERSAMPLE_EN
            acc_q   <= '0;
            rep_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ch_q    <= ch_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            din_q   <= din_d;
            data_q  <= data_d;
            sch_q   <= sch_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
`ifdef ADC_SCAN_OVERSAMPLE_EN
            acc_q   <= acc_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign CS             = cs_q;
    assign SCK            = sck_q;
    assign DIN            = din_q;
    assign processCounter = pc_q;
    assign sampleData     = data_q;
    assign sampleCh       = sch_q;
    assign sampleValid    = vld_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

    logic        controlCLK = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic [7:0]  chMask     = 8'h00;
    logic        DOUT       = 1'b0;
    logic        CS, SCK, DIN, sampleValid, busy;
    logic [5:0]  processCounter;
    logic [11:0] sampleData;
    logic [2:0]  sampleCh;

    int n_checks = 0;
    int n_fail   = 0;

    adc_scan_sequencer #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .controlCLK(controlCLK), .rst_n(rst_n), .enable(enable), .chMask(chMask),
        .CS(CS), .SCK(SCK), .DIN(DIN), .DOUT(DOUT),
        .processCounter(processCounter), .sampleData(sampleData), .sampleCh(sampleCh),
        .sampleValid(sampleValid), .busy(busy)
    );

    always #5 controlCLK = ~controlCLK;

    // ---------------- ADC model ----------------
    // mode 0: fixed value, 1: channel*100 (decoded from DIN), 2: 100+frame index
    int          adc_mode  = 0;
    logic [11:0] fixed_val = 12'h000;
    logic [11:0] adc_val   = 12'h000;
    int          os_idx    = 0;
    int          rise_cnt  = 0;
    int          fall_cnt  = 0;
    int          cs_falls  = 0;
    logic [18:0] din_bits  = '0;

    always @(negedge CS) begin
        rise_cnt = 0;
        fall_cnt = 0;
        cs_falls++;
        DOUT = 1'b0;
        if (adc_mode == 0) adc_val = fixed_val;
        if (adc_mode == 2) begin
            adc_val = 12'(100 + os_idx);
            os_idx++;
        end
    end

    always @(posedge SCK) begin
        if (rise_cnt < 19) din_bits[rise_cnt] = DIN;
        if (rise_cnt == 4 && adc_mode == 1)
            adc_val = 12'({din_bits[2], din_bits[3], din_bits[4]}) * 12'd100;
        rise_cnt++;
    end

    always @(negedge SCK) begin
        fall_cnt++;
        if (fall_cnt >= 7 && fall_cnt <= 18) DOUT = adc_val[18 - fall_cnt];
        else DOUT = 1'b0;
    end

    // ---------------- sample monitor ----------------
    logic [14:0] samples[$];
    logic        prev_vld = 1'b0;

    always @(negedge controlCLK) begin
        if (sampleValid) begin
            n_checks++;
            if (prev_vld) begin
                n_fail++;
                $display("FAIL vld_consecutive: sampleValid=1 on two cycles, required single-cycle strobe");
            end
            samples.push_back({sampleCh, sampleData});
        end
        prev_vld = sampleValid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge controlCLK);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        chMask = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Stop scanning and wait until busy drops.
    task automatic go_idle();
        int t;
        enable = 1'b0;
        t = 0;
        while (busy && t < 600) begin tick(1); t++; end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic wait_samples(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (samples.size() < n && t < budget) begin tick(1); t++; end
        n_checks++;
        if (samples.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d samples required %0d", name, samples.size(), n);
        end
    endtask

    task automatic wait_pc(input logic [5:0] p, input string name);
        int t;
        t = 0;
        while (processCounter !== p && t < 400) begin tick(1); t++; end
        n_checks++;
        if (processCounter !== p) begin
            n_fail++;
            $display("FAIL %s_pc_timeout: processCounter=%0d required %0d", name, processCounter, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({CS, SCK, DIN, processCounter, sampleData, sampleCh, sampleValid, busy} !==
            {1'b1, 1'b0, 1'b0, 6'd0, 12'h000, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: CS=%0b SCK=%0b DIN=%0b pc=%0d data=%h ch=%0d vld=%0b busy=%0b required 1 0 0 0 000 0 0 0",
                     CS, SCK, DIN, processCounter, sampleData, sampleCh, sampleValid, busy);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_frame();
        int low_cnt, gap_cnt;
        logic [5:0] max_pc;
        do_reset();
        samples.delete();
        adc_mode  = 0;
        fixed_val = 12'hA5C;
        enable = 1'b1;
        chMask = 8'h01;
        tick(1);
        n_checks++;
        if (CS !== 1'b0 || busy !== 1'b1 || DIN !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: CS=%0b busy=%0b DIN=%0b required 0 1 1", CS, busy, DIN);
        end
        low_cnt = 0;
        max_pc  = 0;
        while (CS === 1'b0 && low_cnt < 1000) begin
            if (processCounter > max_pc) max_pc = processCounter;
            low_cnt++;
            tick(1);
        end
        n_checks++;
        if (low_cnt != 160) begin
            n_fail++;
            $display("FAIL frame_len: CS low %0d cycles required 160", low_cnt);
        end
        n_checks++;
        if (max_pc !== 6'd18) begin
            n_fail++;
            $display("FAIL max_pc: peak processCounter=%0d required 18", max_pc);
        end
        n_checks++;
        if (sampleValid !== 1'b1 || sampleData !== 12'hA5C || sampleCh !== 3'd0) begin
            n_fail++;
            $display("FAIL single_sample: vld=%0b data=%h ch=%0d required 1 a5c 0", sampleValid, sampleData, sampleCh);
        end
        n_checks++;
        if (din_bits !== 19'b0000000000000000011) begin
            n_fail++;
            $display("FAIL din_seq: DIN bits (p18..p0)=%b required 0000000000000000011", din_bits);
        end
        gap_cnt = 0;
        while (CS === 1'b1 && gap_cnt < 100) begin gap_cnt++; tick(1); end
        n_checks++;
        if (gap_cnt != 8) begin
            n_fail++;
            $display("FAIL gap_len: CS high %0d cycles required 8", gap_cnt);
        end
        go_idle();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch[5];
        exp_ch = '{3'd0, 3'd4, 3'd7, 3'd0, 3'd4};
        do_reset();
        samples.delete();
        adc_mode = 1;
        enable = 1'b1;
        chMask = 8'h91;
        wait_samples(5, 1000, "round_robin");
        for (int i = 0; i < 5 && i < samples.size(); i++) begin
            n_checks++;
            if (samples[i] !== {exp_ch[i], 12'(exp_ch[i] * 100)}) begin
                n_fail++;
                $display("FAIL rr_sample%0d: ch=%0d data=%0d required ch=%0d data=%0d", i,
                         samples[i][14:12], samples[i][11:0], exp_ch[i], exp_ch[i] * 100);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        int low_cnt;
        do_reset();
        samples.delete();
        adc_mode  = 0;
        fixed_val = 12'h3C7;
        enable = 1'b1;
        chMask = 8'h01;
        wait_pc(6'd10, "enable_drop");
        go_idle();
        n_checks++;
        if (samples.size() != 1 || samples[0] !== {3'd0, 12'h3C7}) begin
            n_fail++;
            $display("FAIL drop_sample: count=%0d first=%h required 1 sample 03c7", samples.size(),
                     samples.size() > 0 ? samples[0] : 15'h0);
        end
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (CS !== 1'b1 || busy !== 1'b0) low_cnt++;
            tick(1);
        end
        n_checks++;
        if (low_cnt != 0) begin
            n_fail++;
            $display("FAIL drop_stays_idle: %0d active cycles required 0", low_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        samples.delete();
        adc_mode = 1;
        enable = 1'b1;
        chMask = 8'h06;
        wait_samples(1, 300, "pre_reset");
        wait_pc(6'd12, "reset_mid");
        samples.delete();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (CS !== 1'b1 || SCK !== 1'b0 || busy !== 1'b0 || processCounter !== 6'd0) begin
            n_fail++;
            $display("FAIL async_reset: CS=%0b SCK=%0b busy=%0b pc=%0d required 1 0 0 0", CS, SCK, busy, processCounter);
        end
        tick(3);
        n_checks++;
        if (samples.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: %0d samples required 0", samples.size());
        end
        rst_n = 1'b1;
        wait_samples(1, 300, "post_reset");
        n_checks++;
        if (samples.size() < 1 || samples[0] !== {3'd1, 12'd100}) begin
            n_fail++;
            $display("FAIL post_reset_ch: first=%h required 1064 (ch1, 100)",
                     samples.size() > 0 ? samples[0] : 15'h0);
        end
        go_idle();
    endtask

    task automatic test_zero_mask();
        int act;
        do_reset();
        samples.delete();
        adc_mode = 1;
        enable = 1'b1;
        chMask = 8'h00;
        act = 0;
        for (int i = 0; i < 200; i++) begin
            if (CS !== 1'b1 || busy !== 1'b0) act++;
            tick(1);
        end
        n_checks++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL zero_mask_idle: %0d active cycles required 0", act);
        end
        chMask = 8'h02;
        tick(2);
        n_checks++;
        if (CS !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_start: CS=%0b required 0", CS);
        end
        wait_samples(1, 300, "mask_start");
        n_checks++;
        if (din_bits[4:2] !== 3'b100 || samples.size() < 1 || samples[0] !== {3'd1, 12'd100}) begin
            n_fail++;
            $display("FAIL mask_ch1: DIN p4..p2=%b first=%h required 100 and 1064", din_bits[4:2],
                     samples.size() > 0 ? samples[0] : 15'h0);
        end
        go_idle();
    endtask

    task automatic test_oversample();
        do_reset();
        samples.delete();
        adc_mode = 2;
        os_idx   = 0;
        cs_falls = 0;
        enable = 1'b1;
        chMask = 8'h01;
        wait_samples(1, 800, "oversample");
        n_checks++;
        if (cs_falls != 4 || samples.size() != 1 || samples[0] !== {3'd0, 12'd101}) begin
            n_fail++;
            $display("FAIL oversample: frames=%0d count=%0d first=%h required 4 frames, 1 sample 0065",
                     cs_falls, samples.size(), samples.size() > 0 ? samples[0] : 15'h0);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
`ifdef ADC_SCAN_OVERSAMPLE_EN
        test_oversample();
`else
        test_single_frame();
        test_round_robin();
        test_enable_drop();
        test_reset_mid_frame();
        test_zero_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
